// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, FSM state encoding and block-alignment helper
// for the cache sequencing controller.
//   ADDR_W      word address width (tag + index)
//   DATA_W      cache/memory word width
//   LINE_WORDS  words fetched per memory block read
//   state_t     controller FSM states
//   blk_base()  aligns a word address down to its 4-word block base
package cache_pkg;

  localparam int TAG_W      = 3;
  localparam int IDX_W      = 12;
  localparam int ADDR_W     = TAG_W + IDX_W;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;

  typedef enum logic [3:0] {
    IDLE,
    LOOKUP,
    CHECK,
    CLR_MISS,
    MEM_REQ,
    FILL,
    FILL_WAIT,
    CLR_FILL,
    RESP
  } state_t;

  // Clear the word-in-block bits; the tag and upper index bits are untouched,
  // so an address never wraps into a neighbouring block.
  function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: bundles the CPU, cache and memory handshakes of cache_ctrl.
//   master : controller view (drives cpu_rdy/cpu_valid/cpu_data, cache
//            controls and fill words, memory read request)
//   slave  : environment view (CPU, data cache and main memory)
interface cache_ctrl_if;

  // CPU side
  logic                                           cpu_req;
  logic [cache_pkg::ADDR_W-1:0]                   cpu_adr;
  logic                                           cpu_rdy;
  logic                                           cpu_valid;
  logic [cache_pkg::DATA_W-1:0]                   cpu_data;
  // Data cache side
  logic                                           c_start;
  logic                                           c_we;
  logic                                           c_forc;
  logic [cache_pkg::ADDR_W-1:0]                   c_adr;
  logic [cache_pkg::DATA_W-1:0]                   c_r1;
  logic [cache_pkg::DATA_W-1:0]                   c_r2;
  logic [cache_pkg::DATA_W-1:0]                   c_r3;
  logic [cache_pkg::DATA_W-1:0]                   c_r4;
  logic                                           c_ready;
  logic                                           c_writed;
  logic                                           c_need;
  logic                                           c_find;
  logic [cache_pkg::DATA_W-1:0]                   c_dout;
  // Main memory side
  logic                                           mem_rd;
  logic [cache_pkg::ADDR_W-1:0]                   mem_adr;
  logic                                           mem_valid;
  logic [cache_pkg::LINE_WORDS*cache_pkg::DATA_W-1:0] mem_line;

  modport master (
    input  cpu_req, cpu_adr,
    output cpu_rdy, cpu_valid, cpu_data,
    output c_start, c_we, c_forc, c_adr, c_r1, c_r2, c_r3, c_r4,
    input  c_ready, c_writed, c_need, c_find, c_dout,
    output mem_rd, mem_adr,
    input  mem_valid, mem_line
  );

  modport slave (
    output cpu_req, cpu_adr,
    input  cpu_rdy, cpu_valid, cpu_data,
    input  c_start, c_we, c_forc, c_adr, c_r1, c_r2, c_r3, c_r4,
    output c_ready, c_writed, c_need, c_find, c_dout,
    input  mem_rd, mem_adr,
    output mem_valid, mem_line
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   inc        : count one event this cycle
//   cnt        : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: single-outstanding read sequencer in front of a direct-mapped
// data cache. Looks the word up; on a miss fetches the aligned 4-word block
// from memory, fills the cache, looks up again and returns the word.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (master)      : CPU request/response, cache controls/flags/fill words,
//                       memory block read request/response
//   hit_cnt, miss_cnt : saturating request statistics
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_ctrl_if.master     bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  state_t              state;
  logic [ADDR_W-1:0]   adr;     // address of the request in flight
  logic                relook;  // set once the block has been refilled
  logic                hit_inc;
  logic                miss_inc;

  // Only the first lookup of a request is counted; a re-lookup after a fill
  // (hit or, erroneously, miss) leaves the statistics alone.
  assign hit_inc  = (state == CHECK) && bus.c_ready && bus.c_find && !relook;
  assign miss_inc = (state == CHECK) && bus.c_ready && !bus.c_find &&
                    bus.c_need && !relook;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      adr           <= '0;
      relook        <= 1'b0;
      bus.cpu_rdy   <= 1'b1;
      bus.cpu_valid <= 1'b0;
      bus.cpu_data  <= '0;
      bus.c_start   <= 1'b0;
      bus.c_we      <= 1'b0;
      bus.c_forc    <= 1'b0;
      bus.c_adr     <= '0;
      bus.c_r1      <= '0;
      bus.c_r2      <= '0;
      bus.c_r3      <= '0;
      bus.c_r4      <= '0;
      bus.mem_rd    <= 1'b0;
      bus.mem_adr   <= '0;
    end else begin
      // Single-cycle strobes default low; each state raises what it needs
      // for the following cycle so all outputs are registered.
      bus.cpu_valid <= 1'b0;
      bus.c_start   <= 1'b0;
      bus.c_we      <= 1'b0;
      bus.c_forc    <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            adr         <= bus.cpu_adr;
            relook      <= 1'b0;
            bus.cpu_rdy <= 1'b0;
            bus.c_start <= 1'b1;
            bus.c_adr   <= bus.cpu_adr;
            state       <= LOOKUP;
          end
        end

        LOOKUP: state <= CHECK;

        CHECK: begin
          if (bus.c_ready) begin
            if (bus.c_find) begin
              bus.cpu_data  <= bus.c_dout;
              bus.cpu_valid <= 1'b1;
              bus.c_forc    <= 1'b1;
              state         <= RESP;
            end else if (bus.c_need) begin
              bus.c_forc <= 1'b1;
              state      <= CLR_MISS;
            end
          end
        end

        CLR_MISS: begin
          bus.mem_rd  <= 1'b1;
          bus.mem_adr <= blk_base(adr);
          state       <= MEM_REQ;
        end

        MEM_REQ: begin
          if (bus.mem_valid) begin
            bus.c_r1   <= bus.mem_line[DATA_W-1:0];
            bus.c_r2   <= bus.mem_line[2*DATA_W-1:DATA_W];
            bus.c_r3   <= bus.mem_line[3*DATA_W-1:2*DATA_W];
            bus.c_r4   <= bus.mem_line[4*DATA_W-1:3*DATA_W];
            bus.mem_rd <= 1'b0;
            bus.c_we   <= 1'b1;
            bus.c_adr  <= blk_base(adr);
            state      <= FILL;
          end
        end

        FILL: state <= FILL_WAIT;

        FILL_WAIT: begin
          if (bus.c_writed) begin
            bus.c_forc <= 1'b1;
            state      <= CLR_FILL;
          end
        end

        // Flags were cleared in this cycle, so the re-lookup starts clean.
        CLR_FILL: begin
          relook      <= 1'b1;
          bus.c_start <= 1'b1;
          bus.c_adr   <= adr;
          state       <= LOOKUP;
        end

        RESP: begin
          bus.cpu_rdy <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          bus.cpu_rdy <= 1'b1;
          bus.mem_rd  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (hit_inc),
    .cnt  (hit_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (miss_inc),
    .cnt  (miss_cnt)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl with a behavioural
// direct-mapped cache and a fixed-latency block memory.
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int MEM_LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_if bus();
  logic [15:0] hit_cnt, miss_cnt;

  cache_ctrl #(.CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
  );

  // Narrow stand-alone counter so saturation is reachable in a few cycles.
  logic       sat_inc = 1'b0;
  logic [3:0] sat_cnt;
  sat_counter #(.CNT_W(4)) u_sat (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (sat_inc),
    .cnt  (sat_cnt)
  );

  int ncmp = 0;
  int nfail = 0;

  // ---------------- cache model ----------------
  logic [4095:0] cv;
  logic [2:0]    ctag [4096];
  logic [31:0]   cmem [4096];
  logic [11:0]   cidx;
  logic [11:0]   cbase;
  assign cidx  = bus.c_adr[11:0];
  assign cbase = {bus.c_adr[11:2], 2'b00};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv           <= '0;
      bus.c_ready  <= 1'b0;
      bus.c_writed <= 1'b0;
      bus.c_need   <= 1'b0;
      bus.c_find   <= 1'b0;
      bus.c_dout   <= '0;
    end else begin
      if (bus.c_forc) begin
        bus.c_ready  <= 1'b0;
        bus.c_writed <= 1'b0;
        bus.c_need   <= 1'b0;
        bus.c_find   <= 1'b0;
      end
      if (bus.c_start) begin
        bus.c_ready <= 1'b1;
        if (cv[cidx] && ctag[cidx] == bus.c_adr[14:12]) begin
          bus.c_find <= 1'b1;
          bus.c_dout <= cmem[cidx];
        end else begin
          bus.c_need <= 1'b1;
        end
      end
      if (bus.c_we) begin
        cmem[cbase]        <= bus.c_r1;
        cmem[cbase + 12'd1] <= bus.c_r2;
        cmem[cbase + 12'd2] <= bus.c_r3;
        cmem[cbase + 12'd3] <= bus.c_r4;
        ctag[cbase]        <= bus.c_adr[14:12];
        ctag[cbase + 12'd1] <= bus.c_adr[14:12];
        ctag[cbase + 12'd2] <= bus.c_adr[14:12];
        ctag[cbase + 12'd3] <= bus.c_adr[14:12];
        cv[cbase]          <= 1'b1;
        cv[cbase + 12'd1]  <= 1'b1;
        cv[cbase + 12'd2]  <= 1'b1;
        cv[cbase + 12'd3]  <= 1'b1;
        bus.c_writed       <= 1'b1;
      end
    end
  end

  // ---------------- memory model ----------------
  // Block 0x0004 holds 0xA,0xB,0xC,0xD; every other word is 0x5A00_0000|addr.
  function automatic logic [31:0] mem_word(input logic [14:0] a);
    if ({a[14:2], 2'b00} == 15'h0004) return 32'hA + {30'b0, a[1:0]};
    return {8'h5A, 9'b0, a};
  endfunction

  int   mcnt;
  logic spur = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_valid <= 1'b0;
      bus.mem_line  <= '0;
      mcnt          <= 0;
    end else begin
      bus.mem_valid <= 1'b0;
      if (spur) begin
        bus.mem_valid <= 1'b1;
        bus.mem_line  <= '1;
      end else if (bus.mem_rd && !bus.mem_valid) begin
        if (mcnt == MEM_LAT - 1) begin
          bus.mem_valid <= 1'b1;
          bus.mem_line  <= {mem_word(bus.mem_adr + 15'd3), mem_word(bus.mem_adr + 15'd2),
                            mem_word(bus.mem_adr + 15'd1), mem_word(bus.mem_adr)};
          mcnt          <= 0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU read; a second request with a different address is held during
  // the first busy cycles and must be ignored.
  task automatic rd_check(input string nm, input logic [14:0] a, input logic [31:0] exp_d,
                          input bit miss, input logic [14:0] exp_madr);
    bit          ok, rdy_after;
    int          lat, nmem, nwe, novl;
    logic [31:0] d;
    logic [14:0] madr;
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_adr = a;
    @(posedge clk);
    ok = 0; rdy_after = 0; lat = 0; nmem = 0; nwe = 0; novl = 0; d = '0; madr = '0;
    for (int k = 1; k <= 80 && !ok; k++) begin
      @(negedge clk);
      if (k == 1) bus.cpu_adr = ~a;
      if (k == 2) bus.cpu_req = 1'b0;
      if (bus.mem_rd) begin nmem++; madr = bus.mem_adr; end
      if (bus.c_we) nwe++;
      if (bus.c_we && bus.c_start) novl++;
      if (bus.cpu_valid) begin ok = 1; lat = k; d = bus.cpu_data; end
    end
    bus.cpu_req = 1'b0;
    if (ok) begin
      @(negedge clk);
      rdy_after = bus.cpu_rdy;
    end
    chk({nm, "_done"}, {31'b0, ok}, 32'd1);
    chk({nm, "_data"}, d, exp_d);
    chk({nm, "_rdy_back"}, {31'b0, rdy_after}, 32'd1);
    chk({nm, "_we_start_overlap"}, novl, 32'd0);
    if (miss) begin
      chk({nm, "_mem_adr"}, {17'b0, madr}, {17'b0, exp_madr});
      chk({nm, "_we_pulses"}, nwe, 32'd1);
    end else begin
      chk({nm, "_latency"}, lat, 32'd3);
      chk({nm, "_mem_rd_cycles"}, nmem, 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit seen;
    int nvalid;
    bus.cpu_req = 1'b0;
    bus.cpu_adr = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_rdy", {31'b0, bus.cpu_rdy}, 32'd1);
    chk("rst_strobes", {27'b0, bus.cpu_valid, bus.c_start, bus.c_we, bus.c_forc, bus.mem_rd}, 32'd0);
    chk("rst_cpu_data", bus.cpu_data, 32'd0);
    chk("rst_c_adr", {17'b0, bus.c_adr}, 32'd0);
    chk("rst_mem_adr", {17'b0, bus.mem_adr}, 32'd0);
    chk("rst_c_r", bus.c_r1 | bus.c_r2 | bus.c_r3 | bus.c_r4, 32'd0);
    chk("rst_counters", {hit_cnt, miss_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cpu_rdy", {31'b0, bus.cpu_rdy}, 32'd1);

    // Cold miss, then hits in the same block
    rd_check("cold_0005", 15'h0005, 32'hB, 1'b1, 15'h0004);
    chk("cold_miss_cnt", miss_cnt, 32'd1);
    chk("cold_hit_cnt", hit_cnt, 32'd0);
    chk("fill_words", {bus.c_r4[7:0], bus.c_r3[7:0], bus.c_r2[7:0], bus.c_r1[7:0]}, 32'h0D0C0B0A);
    rd_check("hit_0004", 15'h0004, 32'hA, 1'b0, 15'h0);
    rd_check("hit_0007", 15'h0007, 32'hD, 1'b0, 15'h0);
    chk("hits_hit_cnt", hit_cnt, 32'd2);
    chk("hits_miss_cnt", miss_cnt, 32'd1);

    // Conflict on index 5 with tag 1, then the evicted line misses again
    rd_check("conf_1005", 15'h1005, 32'h5A001005, 1'b1, 15'h1004);
    chk("conf_miss_cnt", miss_cnt, 32'd2);
    rd_check("evict_0005", 15'h0005, 32'hB, 1'b1, 15'h0004);
    chk("evict_miss_cnt", miss_cnt, 32'd3);
    chk("evict_hit_cnt", hit_cnt, 32'd2);

    // Spurious mem_valid while idle
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    @(negedge clk);
    chk("spur_c_r1", bus.c_r1, 32'hA);
    chk("spur_idle", {29'b0, bus.cpu_rdy, bus.mem_rd, bus.c_we}, 32'd4);

    // Reset while a block read is outstanding
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_adr = 15'h2005;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.mem_rd) seen = 1;
      else @(negedge clk);
    end
    chk("abort_mem_rd_seen", {31'b0, seen}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_rd_async", {31'b0, bus.mem_rd}, 32'd0);
    chk("abort_counters", {hit_cnt, miss_cnt}, 32'd0);
    chk("abort_cpu_rdy", {31'b0, bus.cpu_rdy}, 32'd1);
    nvalid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.cpu_valid) nvalid++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.cpu_valid) nvalid++;
    end
    chk("abort_no_cpu_valid", nvalid, 32'd0);

    rd_check("after_rst_2005", 15'h2005, 32'h5A002005, 1'b1, 15'h2004);
    chk("after_rst_miss_cnt", miss_cnt, 32'd1);
    rd_check("hit_2007", 15'h2007, 32'h5A002007, 1'b0, 15'h0);
    rd_check("align_300b", 15'h300B, 32'h5A00300B, 1'b1, 15'h3008);
    rd_check("hit_3008", 15'h3008, 32'h5A003008, 1'b0, 15'h0);
    chk("final_hit_cnt", hit_cnt, 32'd2);
    chk("final_miss_cnt", miss_cnt, 32'd2);

    // Saturation: count to all-ones minus one, then three more events
    @(negedge clk); sat_inc = 1'b1;
    repeat (14) @(negedge clk);
    sat_inc = 1'b0;
    @(negedge clk);
    chk("sat_pre", {28'b0, sat_cnt}, 32'hE);
    sat_inc = 1'b1;
    repeat (3) @(negedge clk);
    sat_inc = 1'b0;
    @(negedge clk);
    chk("sat_hold", {28'b0, sat_cnt}, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
